// File: rtl/ice_bus_pkg.sv
// ICE slave bus shared definitions.
// Widths, header size and the message transmitter state encoding.
package ice_bus_pkg;
   localparam int SL_DATA_W = 9;
   localparam int SL_ADDR_W = 9;
   localparam int HDR_LEN   = 3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FILL     = 3'd1,
      ST_REQ      = 3'd2,
      ST_HDR_TYPE = 3'd3,
      ST_HDR_EVT  = 3'd4,
      ST_HDR_LEN  = 3'd5,
      ST_PAYLOAD  = 3'd6,
      ST_COMMIT   = 3'd7
   } tx_state_t;
endpackage

// File: rtl/ice_msg_buf.sv
// Payload staging buffer: simple dual-port RAM, synchronous read.
// Contents are not reset; only bytes written in FILL are ever read.
module ice_msg_buf #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);
   logic [7:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/ice_sl_msg_tx.sv
// Slave-side message transmitter: buffers one client message, then
// writes type/evt/len/payload into the controller buffer and latches tail.
module ice_sl_msg_tx
   import ice_bus_pkg::*;
#(
   parameter int AW      = 8,
   parameter int MAX_LEN = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 msg_start,
   input  logic [7:0]           msg_type,
   input  logic [7:0]           msg_evt_id,
   input  logic [7:0]           msg_data,
   input  logic                 msg_data_valid,
   input  logic                 msg_end,
   output logic                 msg_ready,
   output logic                 msg_done,
   output logic                 msg_dropped,
   input  logic [SL_ADDR_W-1:0] sl_tail_in,
   input  logic                 sl_overflow,
   input  logic                 sl_arb_grant,
   output logic                 sl_arb_request,
   output logic [SL_ADDR_W-1:0] sl_addr,
   output logic [SL_DATA_W-1:0] sl_data,
   output logic [SL_ADDR_W-1:0] sl_tail,
   output logic                 sl_latch_tail
);
   tx_state_t state, nxt;
   logic [7:0] typ, evt, len, rptr, rd_data;
   logic [AW-1:0] wptr;
   logic [SL_ADDR_W-1:0] base, len9, rptr9;
   logic push, rd_en, abort, start_ok;

   assign len9     = SL_ADDR_W'(len);
   assign rptr9    = SL_ADDR_W'(rptr);
   assign abort    = sl_overflow | ~sl_arb_grant;
   assign start_ok = msg_start & (state == ST_IDLE || state == ST_FILL);

   ice_msg_buf #(.AW(AW)) u_buf (
      .clk   (clk),
      .we    (push),
      .waddr (wptr),
      .wdata (msg_data),
      .re    (rd_en),
      .raddr (AW'(rptr)),
      .rdata (rd_data)
   );

   always_comb begin
      nxt            = state;
      msg_ready      = 1'b0;
      msg_done       = 1'b0;
      msg_dropped    = 1'b0;
      sl_arb_request = 1'b0;
      sl_addr        = '0;
      sl_data        = '0;
      sl_tail        = '0;
      sl_latch_tail  = 1'b0;
      push           = 1'b0;
      rd_en          = 1'b0;
      unique case (state)
         ST_IDLE: begin
            msg_ready = 1'b1;
            if (msg_start) nxt = ST_FILL;
         end
         ST_FILL: begin
            if (!msg_start) begin
               if (msg_data_valid && len == 8'(MAX_LEN)) begin
                  msg_dropped = 1'b1;
                  nxt         = ST_IDLE;
               end else begin
                  push = msg_data_valid;
                  if (msg_end) nxt = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            sl_arb_request = 1'b1;
            if (sl_arb_grant) nxt = ST_HDR_TYPE;
         end
         ST_HDR_TYPE: begin
            sl_arb_request = 1'b1;
            if (abort) begin
               msg_dropped = 1'b1;
               nxt         = ST_IDLE;
            end else begin
               sl_addr = base;
               sl_data = {1'b1, typ};
               nxt     = ST_HDR_EVT;
            end
         end
         ST_HDR_EVT: begin
            sl_arb_request = 1'b1;
            if (abort) begin
               msg_dropped = 1'b1;
               nxt         = ST_IDLE;
            end else begin
               sl_addr = base + SL_ADDR_W'(1);
               sl_data = {1'b1, evt};
               nxt     = ST_HDR_LEN;
            end
         end
         ST_HDR_LEN: begin
            sl_arb_request = 1'b1;
            if (abort) begin
               msg_dropped = 1'b1;
               nxt         = ST_IDLE;
            end else begin
               // Prefetch payload byte 0 so PAYLOAD runs without bubbles
               sl_addr = base + SL_ADDR_W'(HDR_LEN - 1);
               sl_data = {1'b1, len};
               rd_en   = 1'b1;
               nxt     = (len == 8'd0) ? ST_COMMIT : ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            sl_arb_request = 1'b1;
            if (abort) begin
               msg_dropped = 1'b1;
               nxt         = ST_IDLE;
            end else begin
               sl_addr = base + SL_ADDR_W'(HDR_LEN - 1) + rptr9;
               sl_data = {1'b1, rd_data};
               rd_en   = 1'b1;
               if (rptr == len) nxt = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            sl_arb_request = 1'b1;
            nxt            = ST_IDLE;
            if (abort) begin
               msg_dropped = 1'b1;
            end else begin
               sl_tail       = base + SL_ADDR_W'(HDR_LEN) + len9;
               sl_latch_tail = 1'b1;
               msg_done      = 1'b1;
            end
         end
         default: nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         typ   <= '0;
         evt   <= '0;
         len   <= '0;
         wptr  <= '0;
         rptr  <= '0;
         base  <= '0;
      end else begin
         state <= nxt;
         if (start_ok) begin
            typ  <= msg_type;
            evt  <= msg_evt_id;
            len  <= '0;
            wptr <= '0;
         end else if (push) begin
            len  <= len + 8'd1;
            wptr <= wptr + AW'(1);
         end
         if (state == ST_REQ && sl_arb_grant) begin
            base <= sl_tail_in;
            rptr <= '0;
         end else if (rd_en) begin
            rptr <= rptr + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_ice_sl_msg_tx.sv
// Self-checking bench for ice_sl_msg_tx: directed scenarios plus
// randomized messages checked against a frame-level reference model.
module tb_ice_sl_msg_tx;
   localparam int MAXL = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       msg_start = 1'b0;
   logic [7:0] msg_type = '0;
   logic [7:0] msg_evt_id = '0;
   logic [7:0] msg_data = '0;
   logic       msg_data_valid = 1'b0;
   logic       msg_end = 1'b0;
   logic       msg_ready, msg_done, msg_dropped;
   logic [8:0] sl_tail_in = '0;
   logic       sl_overflow = 1'b0;
   logic       sl_arb_grant = 1'b0;
   logic       sl_arb_request;
   logic [8:0] sl_addr, sl_data, sl_tail;
   logic       sl_latch_tail;

   int vectors = 0;
   int errs = 0;

   int dcnt = 0;
   int drop_cnt = 0;
   int req_cnt = 0;
   int latch_nodone = 0;
   logic [16:0] wq[$];
   logic [8:0]  lq[$];
   logic [7:0]  pl[$];

   always #5 clk = ~clk;

   ice_sl_msg_tx #(.AW(8), .MAX_LEN(MAXL)) dut (
      .clk            (clk),
      .reset          (reset),
      .msg_start      (msg_start),
      .msg_type       (msg_type),
      .msg_evt_id     (msg_evt_id),
      .msg_data       (msg_data),
      .msg_data_valid (msg_data_valid),
      .msg_end        (msg_end),
      .msg_ready      (msg_ready),
      .msg_done       (msg_done),
      .msg_dropped    (msg_dropped),
      .sl_tail_in     (sl_tail_in),
      .sl_overflow    (sl_overflow),
      .sl_arb_grant   (sl_arb_grant),
      .sl_arb_request (sl_arb_request),
      .sl_addr        (sl_addr),
      .sl_data        (sl_data),
      .sl_tail        (sl_tail),
      .sl_latch_tail  (sl_latch_tail)
   );

   // Bus monitor: records every strobed write and every tail latch
   always @(negedge clk) begin
      if (!reset) begin
         if (sl_data[8]) wq.push_back({sl_addr, sl_data[7:0]});
         if (sl_latch_tail) begin
            lq.push_back(sl_tail);
            if (!msg_done) latch_nodone <= latch_nodone + 1;
         end
         if (msg_done) dcnt <= dcnt + 1;
         if (msg_dropped) drop_cnt <= drop_cnt + 1;
         if (sl_arb_request) req_cnt <= req_cnt + 1;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference frame: type, id, len, payload... at base+k mod 512
   function automatic logic [7:0] exp_byte(int k, logic [7:0] t,
                                           logic [7:0] id);
      if (k == 0) return t;
      if (k == 1) return id;
      if (k == 2) return 8'(pl.size());
      return pl[k-3];
   endfunction

   task automatic fill(input logic [7:0] t, input logic [7:0] id);
      msg_start = 1'b1;
      msg_type = t;
      msg_evt_id = id;
      cyc();
      msg_start = 1'b0;
      if (pl.size() == 0) begin
         msg_end = 1'b1;
         cyc();
      end else begin
         foreach (pl[i]) begin
            msg_data_valid = 1'b1;
            msg_data = pl[i];
            msg_end = (i == pl.size() - 1);
            cyc();
         end
      end
      msg_data_valid = 1'b0;
      msg_end = 1'b0;
   endtask

   task automatic grant_run(input string nm, input logic [7:0] t,
                            input logic [7:0] id, input logic [8:0] base,
                            input int gd);
      int w0, l0, d0, x0, k;
      logic [16:0] ex;
      w0 = wq.size();
      l0 = lq.size();
      d0 = dcnt;
      x0 = drop_cnt;
      k = 0;
      repeat (gd) begin
         vectors++;
         if (sl_arb_request !== 1'b1) begin
            errs++;
            $display("FAIL %s req_hold: got %b want 1", nm, sl_arb_request);
         end
         cyc();
      end
      sl_tail_in = base;
      sl_arb_grant = 1'b1;
      while (dcnt == d0 && k < 40) begin
         cyc();
         k++;
      end
      sl_arb_grant = 1'b0;
      sl_tail_in = '0;
      vectors++;
      if (dcnt != d0 + 1) begin
         errs++;
         $display("FAIL %s done_cnt: got %0d want %0d", nm, dcnt - d0, 1);
      end
      vectors++;
      if (wq.size() - w0 != pl.size() + 3) begin
         errs++;
         $display("FAIL %s write_cnt: got %0d want %0d", nm,
                  wq.size() - w0, pl.size() + 3);
      end
      for (int j = 0; j < pl.size() + 3 && w0 + j < wq.size(); j++) begin
         ex = {9'(int'(base) + j), exp_byte(j, t, id)};
         vectors++;
         if (wq[w0+j] !== ex) begin
            errs++;
            $display("FAIL %s write%0d: got %h want %h", nm, j, wq[w0+j], ex);
         end
      end
      vectors++;
      if (lq.size() != l0 + 1) begin
         errs++;
         $display("FAIL %s latch_cnt: got %0d want 1", nm, lq.size() - l0);
      end else if (lq[l0] !== 9'(int'(base) + 3 + pl.size())) begin
         errs++;
         $display("FAIL %s tail: got %h want %h", nm, lq[l0],
                  9'(int'(base) + 3 + pl.size()));
      end
      vectors++;
      if (latch_nodone != 0 || drop_cnt != x0) begin
         errs++;
         $display("FAIL %s done_align: got nodone=%0d drops=%0d want 0",
                  nm, latch_nodone, drop_cnt - x0);
      end
      vectors++;
      if (msg_ready !== 1'b1) begin
         errs++;
         $display("FAIL %s ready_after: got %b want 1", nm, msg_ready);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({msg_ready, msg_done, msg_dropped, sl_arb_request} !== 4'b1000) begin
         errs++;
         $display("FAIL reset_ctl: got %b want 1000",
                  {msg_ready, msg_done, msg_dropped, sl_arb_request});
      end
      vectors++;
      if ({sl_addr, sl_data, sl_tail, sl_latch_tail} !== 28'd0) begin
         errs++;
         $display("FAIL reset_bus: got %h want 0",
                  {sl_addr, sl_data, sl_tail, sl_latch_tail});
      end
      @(negedge clk);
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_idle_ignore();
      int r0;
      r0 = req_cnt;
      msg_data_valid = 1'b1;
      msg_end = 1'b1;
      cyc();
      msg_data_valid = 1'b0;
      msg_end = 1'b0;
      cyc();
      vectors++;
      if (msg_ready !== 1'b1 || req_cnt != r0) begin
         errs++;
         $display("FAIL idle_ignore: got ready=%b req=%0d want 1/0",
                  msg_ready, req_cnt - r0);
      end
   endtask

   task automatic test_basic();
      pl = '{8'h11, 8'h22, 8'h33};
      fill(8'h47, 8'h05);
      grant_run("basic", 8'h47, 8'h05, 9'h010, 1);
   endtask

   task automatic test_zero();
      pl = {};
      fill(8'h52, 8'h09);
      grant_run("zero", 8'h52, 8'h09, 9'h100, 0);
   endtask

   task automatic test_wrap();
      pl = '{8'hA5, 8'h5A};
      fill(8'h4D, 8'h7F);
      grant_run("wrap", 8'h4D, 8'h7F, 9'h1FE, 2);
   endtask

   task automatic test_restart();
      msg_start = 1'b1;
      msg_type = 8'hEE;
      msg_evt_id = 8'hEE;
      cyc();
      msg_start = 1'b0;
      msg_data_valid = 1'b1;
      msg_data = 8'hCC;
      repeat (3) cyc();
      msg_data_valid = 1'b0;
      pl = '{8'h01};
      fill(8'h50, 8'h02);
      grant_run("restart", 8'h50, 8'h02, 9'h0A0, 0);
   endtask

   task automatic test_overlen();
      int r0;
      r0 = req_cnt;
      msg_start = 1'b1;
      msg_type = 8'h45;
      cyc();
      msg_start = 1'b0;
      for (int i = 0; i <= MAXL; i++) begin
         msg_data_valid = 1'b1;
         msg_data = 8'(i);
         #1;
         vectors++;
         if (msg_dropped !== (i == MAXL)) begin
            errs++;
            $display("FAIL overlen_push%0d: got dropped=%b want %b",
                     i, msg_dropped, (i == MAXL));
         end
         cyc();
      end
      msg_data_valid = 1'b0;
      vectors++;
      if (msg_ready !== 1'b1) begin
         errs++;
         $display("FAIL overlen_ready: got %b want 1", msg_ready);
      end
      repeat (3) cyc();
      vectors++;
      if (req_cnt != r0) begin
         errs++;
         $display("FAIL overlen_req: got %0d want 0", req_cnt - r0);
      end
   endtask

   task automatic test_overflow();
      int w0, l0;
      w0 = wq.size();
      l0 = lq.size();
      pl = '{8'h61, 8'h62, 8'h63};
      fill(8'h4F, 8'h11);
      sl_tail_in = 9'h040;
      sl_arb_grant = 1'b1;
      repeat (5) cyc();
      sl_overflow = 1'b1;
      #1;
      vectors++;
      if ({sl_data[8], msg_dropped, sl_latch_tail, sl_arb_request} !== 4'b0101) begin
         errs++;
         $display("FAIL ovf_cycle: got %b want 0101",
                  {sl_data[8], msg_dropped, sl_latch_tail, sl_arb_request});
      end
      cyc();
      sl_overflow = 1'b0;
      sl_arb_grant = 1'b0;
      vectors++;
      if (sl_arb_request !== 1'b0 || msg_ready !== 1'b1) begin
         errs++;
         $display("FAIL ovf_after: got req=%b ready=%b want 0/1",
                  sl_arb_request, msg_ready);
      end
      repeat (3) cyc();
      vectors++;
      if (wq.size() - w0 != 4 || lq.size() != l0) begin
         errs++;
         $display("FAIL ovf_writes: got w=%0d l=%0d want 4/0",
                  wq.size() - w0, lq.size() - l0);
      end else if (wq[w0+3] !== {9'h043, 8'h61}) begin
         errs++;
         $display("FAIL ovf_last: got %h want %h", wq[w0+3], {9'h043, 8'h61});
      end
   endtask

   task automatic test_reset_mid();
      int l0, d0;
      l0 = lq.size();
      d0 = dcnt;
      pl = '{8'h01, 8'h02};
      fill(8'h49, 8'h22);
      sl_tail_in = 9'h080;
      sl_arb_grant = 1'b1;
      repeat (3) cyc();
      vectors++;
      if (sl_data !== {1'b1, 8'h02} || sl_addr !== 9'h082) begin
         errs++;
         $display("FAIL rst_hdrlen: got %h@%h want 102@082", sl_data, sl_addr);
      end
      #1 reset = 1'b1;
      #1;
      vectors++;
      if ({sl_addr, sl_data, sl_tail, sl_latch_tail, sl_arb_request} !== 29'd0) begin
         errs++;
         $display("FAIL rst_async: got %h want 0",
                  {sl_addr, sl_data, sl_tail, sl_latch_tail, sl_arb_request});
      end
      sl_arb_grant = 1'b0;
      sl_tail_in = '0;
      @(negedge clk);
      reset = 1'b0;
      cyc();
      vectors++;
      if (msg_ready !== 1'b1 || lq.size() != l0 || dcnt != d0) begin
         errs++;
         $display("FAIL rst_release: got ready=%b latch=%0d want 1/0",
                  msg_ready, lq.size() - l0);
      end
   endtask

   task automatic test_random();
      logic [7:0] t, id;
      logic [8:0] b;
      int n;
      for (int it = 0; it < 30; it++) begin
         n = $urandom_range(0, MAXL);
         pl = {};
         for (int j = 0; j < n; j++) pl.push_back(8'($urandom));
         t = 8'($urandom);
         id = 8'($urandom);
         b = 9'($urandom_range(0, 511));
         fill(t, id);
         grant_run($sformatf("rand%0d", it), t, id, b,
                   $urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_idle_ignore();
      test_basic();
      test_zero();
      test_wrap();
      test_restart();
      test_overlen();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/ice_sl_msg_tx.md
Name: ice_sl_msg_tx

Overview:
- Generic slave-side message transmitter for the ICE internal bus; the sending end of the slave output bus that the bus controller drains to the UART.
- A client interface (GPIO, PMU, MBus, EIN style) builds one response or event message: type, event id and payload bytes.
- The block buffers the message, arbitrates for the shared slave bus, writes the framed message into the controller buffer, then commits it with a tail latch.

Parameters:
- AW, 8, payload buffer address width; buffer depth is 2^AW bytes.
- MAX_LEN, 255, maximum payload bytes per message (≤ 2^AW, ≤ 255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- msg_start  in  1  begin a message; samples msg_type and msg_evt_id
- msg_type  in  8  message type character
- msg_evt_id  in  8  event id byte
- msg_data  in  8  payload byte
- msg_data_valid  in  1  push msg_data into the buffer
- msg_end  in  1  close the message and hand it to the bus
- msg_ready  out  1  high in IDLE only
- msg_done  out  1  one-cycle pulse when a message is committed
- msg_dropped  out  1  one-cycle pulse when a message is discarded
- sl_tail_in  in  9  controller's current buffer tail (write base)
- sl_overflow  in  1  controller buffer full
- sl_arb_grant  in  1  arbitration grant for this device
- sl_arb_request  out  1  arbitration request
- sl_addr  out  9  controller buffer write address
- sl_data  out  9  {write strobe, byte}
- sl_tail  out  9  new tail value
- sl_latch_tail  out  1  commit strobe

Behaviour:
- Reset: state IDLE; all outputs 0 except msg_ready=1; length counter, read pointer and write pointer cleared.
- Bus outputs sl_addr, sl_data, sl_tail and sl_latch_tail are forced to 0 whenever the block is not in a bus-driving state. This makes the outputs safe to OR onto the shared bus.
- IDLE:
  - msg_start → latch type and evt_id, clear length, go to FILL.
  - msg_data_valid and msg_end are ignored in IDLE.
- FILL:
  - msg_data_valid writes the byte at wptr and increments len.
  - msg_end → REQ. A msg_data_valid in the same cycle as msg_end is accepted first.
  - A push that would make len > MAX_LEN → pulse msg_dropped, go to IDLE.
  - msg_start while in FILL restarts the message: new type and id, len=0.
- REQ:
  - Assert sl_arb_request and hold it through COMMIT.
  - On sl_arb_grant: base ← sl_tail_in, go to HDR_TYPE.
  - Request is deasserted in IDLE only.
- Header writes, one per cycle, strobe sl_data[8]=1:
  - HDR_TYPE writes msg_type at base.
  - HDR_EVT writes evt_id at base+1.
  - HDR_LEN writes len at base+2.
- PAYLOAD:
  - Byte i is written at base+3+i, one per cycle.
  - The buffer is read one cycle ahead, so there are no bubbles.
  - len=0 skips PAYLOAD.
- Addresses use 9-bit modulo arithmetic; wrap from 511 to 0 is legal.
- COMMIT:
  - Pulse sl_latch_tail for one cycle with sl_tail = base+3+len (mod 512).
  - Pulse msg_done in the same cycle, then go to IDLE.
- Latency: from grant to sl_latch_tail is 3+len cycles, then the COMMIT cycle.
- sl_overflow high in any write state or COMMIT:
  - The current write is suppressed (strobe 0) and no tail is latched.
  - Pulse msg_dropped, go to IDLE.
- Grant deasserted mid-stream: abort exactly as for overflow.
- Reset mid-operation: immediate return to reset values; no partial commit.

Decomposition:
- Shared package ice_bus_pkg:
  - SL_DATA_W=9
  - SL_ADDR_W=9
  - HDR_LEN=3
  - state encoding constants
- One sub-module: ice_msg_buf, a 2^AW×8 simple dual-port RAM with synchronous read.

Test Plan:
- Basic message:
  - Stimulus: start type=0x47 id=0x05, payload 0x11,0x22,0x33, end; grant with sl_tail_in=0x010.
  - Required: writes (0x010,0x47), (0x011,0x05), (0x012,0x03), (0x013,0x11), (0x014,0x22), (0x015,0x33).
  - Required: sl_latch_tail with sl_tail=0x016 and msg_done in the same cycle.
- Zero payload:
  - Stimulus: start then end immediately; sl_tail_in=0x100.
  - Required: 3 header writes, then tail 0x103.
- Wrap:
  - Stimulus: sl_tail_in=0x1FE, len=2.
  - Required: writes to 0x1FE, 0x1FF, 0x000, 0x001, 0x002; tail 0x003.
- Over-length:
  - Stimulus: MAX_LEN=4, push 5 bytes.
  - Required: msg_dropped pulse on the 5th push, no sl_arb_request, msg_ready returns high.
- Overflow:
  - Stimulus: assert sl_overflow during the 2nd payload write.
  - Required: that write's strobe is 0, no sl_latch_tail, msg_dropped pulse, request drops next cycle.
- Reset mid-stream:
  - Stimulus: assert reset during HDR_LEN.
  - Required: all bus outputs 0 asynchronously; msg_ready=1 after reset release.
